// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - opcodes, FSM state enum and operand-usage helpers for hazard_detection
package hazard_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_FREEZE   = 2'd2
  } hz_state_e;

  // rs1 is read by everything except the U-type instructions and JAL
  function automatic logic rs1_used(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  // rs2 is read only by R-type, stores and branches
  function automatic logic rs2_used(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  // Loads and stores are the only instructions that wait on data memory
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/hazard_stats.sv
// rtl/hazard_stats.sv - saturating stall/flush/freeze event counters
module hazard_stats
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  input  logic             freeze_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o,
  output logic [CNT_W-1:0] freeze_cycles_o
);

  logic [CNT_W-1:0] stall_q,  stall_d;
  logic [CNT_W-1:0] flush_q,  flush_d;
  logic [CNT_W-1:0] freeze_q, freeze_d;

  // Each counter advances by one on its event and sticks at all-ones
  always_comb begin
    stall_d  = stall_q;
    flush_d  = flush_q;
    freeze_d = freeze_q;
    if (stall_inc_i && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
    if (flush_inc_i && !(&flush_q)) begin
      flush_d = flush_q + 1'b1;
    end
    if (freeze_inc_i && !(&freeze_q)) begin
      freeze_d = freeze_q + 1'b1;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      freeze_q <= freeze_d;
    end
  end

  assign stall_cycles_o  = stall_q;
  assign flush_count_o   = flush_q;
  assign freeze_cycles_o = freeze_q;

endmodule

// File: rtl/hazard_detection.sv
// rtl/hazard_detection.sv - load-use / redirect / memory-wait pipeline control; HAZARD_STATS_EN adds event counters
module hazard_detection
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       ex_rd,
  input  logic [6:0]       ex_opcode,
  input  logic             ex_redirect,
  input  logic [6:0]       mem_opcode,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] freeze_cycles,
`endif
  output logic [1:0]       hz_state
);

  hz_state_e state_q, state_d;

  logic load_use;
  logic mem_wait;
  logic take_wait;
  logic take_redirect;
  logic take_load_use;

  // Raw hazard detection; ex_rd != 0 also keeps x0 from ever matching
  always_comb begin
    load_use = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
               ((rs1_used(id_opcode) && (id_rs1 == ex_rd)) ||
                (rs2_used(id_opcode) && (id_rs2 == ex_rd)));
    mem_wait = is_mem_op(mem_opcode) && !dmem_ready;
  end

  // Priority resolution; while reset is held every case is suppressed so the
  // outputs show the plain RUN values. A redirect seen during a freeze simply
  // waits here until dmem_ready lets it win.
  always_comb begin
    take_wait     = !reset && mem_wait;
    take_redirect = !reset && !mem_wait && ex_redirect;
    take_load_use = !reset && !mem_wait && !ex_redirect && load_use;
  end

  // Next state and control outputs; defaults are the no-hazard RUN values
  always_comb begin
    state_d      = HZ_RUN;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    if (take_wait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = HZ_FREEZE;
    end else if (take_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      state_d      = HZ_RUN;
    end else if (take_load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
      state_d      = HZ_LU_STALL;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_STATS_EN
  hazard_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk             (clk),
    .reset           (reset),
    .stall_inc_i     (take_load_use),
    .flush_inc_i     (take_redirect),
    .freeze_inc_i    (take_wait),
    .stall_cycles_o  (stall_cycles),
    .flush_count_o   (flush_count),
    .freeze_cycles_o (freeze_cycles)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_detection.sv
// tb/tb_hazard_detection.sv - directed self-checking bench for hazard_detection
module tb_hazard_detection;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}
  localparam logic [6:0] C_RUN = 7'b1101010;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_RED = 7'b1111110;
  localparam logic [6:0] C_WT  = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [6:0] id_opcode, ex_opcode, mem_opcode;
  logic       ex_redirect, dmem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
  logic [1:0] hz_state;
`ifdef HAZARD_STATS_EN
  logic [3:0] stall_cycles, flush_count, freeze_cycles;
`endif
  logic [6:0] ctl;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush};

  hazard_detection #(.CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_opcode    (id_opcode),
    .ex_rd        (ex_rd),
    .ex_opcode    (ex_opcode),
    .ex_redirect  (ex_redirect),
    .mem_opcode   (mem_opcode),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_write (ex_mem_write),
    .mem_wb_flush (mem_wb_flush),
`ifdef HAZARD_STATS_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .freeze_cycles(freeze_cycles),
`endif
    .hz_state     (hz_state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_opcode = 7'd0;
    ex_rd = 5'd0; ex_opcode = 7'd0; ex_redirect = 1'b0;
    mem_opcode = 7'd0; dmem_ready = 1'b1;
  endtask

  // Inputs are already applied; check combinational controls mid-cycle,
  // then the registered state just after the next rising edge.
  task automatic step(input string tag, input logic [6:0] ctl_exp, input logic [1:0] st_exp);
    #2;
    chk({tag, "_ctl"}, {1'b0, ctl}, {1'b0, ctl_exp});
    @(posedge clk);
    #1;
    chk({tag, "_state"}, {6'd0, hz_state}, {6'd0, st_exp});
  endtask

  initial begin
    // Reset held with a load-use pattern present: outputs stay at RUN values
    idle();
    reset = 1'b1;
    ex_opcode = OP_LOAD; ex_rd = 5'd5; id_opcode = OP_RTYPE; id_rs2 = 5'd5;
    step("reset", C_RUN, 2'd0);
`ifdef HAZARD_STATS_EN
    chk("reset_stall_cnt", {4'd0, stall_cycles}, 8'd0);
`endif
    reset = 1'b0;
    idle();
    step("idle", C_RUN, 2'd0);

    // Load-use on rs2, then the bubble in EX releases it
    ex_opcode = OP_LOAD; ex_rd = 5'd5; id_opcode = OP_RTYPE; id_rs1 = 5'd1; id_rs2 = 5'd5;
    step("lu_rs2", C_LU, 2'd1);
    ex_rd = 5'd0;
    step("lu_release", C_RUN, 2'd0);

    // No false stalls: load to x0, LUI does not read rs1, I-type ignores rs2
    ex_opcode = OP_LOAD; ex_rd = 5'd0; id_opcode = OP_RTYPE; id_rs1 = 5'd0; id_rs2 = 5'd0;
    step("no_x0", C_RUN, 2'd0);
    ex_rd = 5'd7; id_opcode = OP_LUI; id_rs1 = 5'd7;
    step("no_lui", C_RUN, 2'd0);
    ex_rd = 5'd3; id_opcode = OP_IMM; id_rs1 = 5'd4; id_rs2 = 5'd3;
    step("no_imm_rs2", C_RUN, 2'd0);

    // Store reads rs2
    ex_rd = 5'd7; id_opcode = OP_STORE; id_rs1 = 5'd3; id_rs2 = 5'd7;
    step("lu_store", C_LU, 2'd1);

    // Redirect beats a concurrent load-use
    ex_rd = 5'd5; id_opcode = OP_RTYPE; id_rs1 = 5'd5; id_rs2 = 5'd0; ex_redirect = 1'b1;
    step("redir_over_lu", C_RED, 2'd0);
`ifdef HAZARD_STATS_EN
    chk("stall_cnt_2", {4'd0, stall_cycles}, 8'd2);
    chk("flush_cnt_1", {4'd0, flush_count}, 8'd1);
`endif

    // Memory wait for three cycles, then resume
    idle();
    mem_opcode = OP_LOAD; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("wait3", C_WT, 2'd2);
    dmem_ready = 1'b1;
    step("wait3_resume", C_RUN, 2'd0);
`ifdef HAZARD_STATS_EN
    chk("freeze_cnt_3", {4'd0, freeze_cycles}, 8'd3);
`endif

    // Redirect held through a two-cycle store freeze, applied on ready
    mem_opcode = OP_STORE; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 2; i++) step("redir_frz", C_WT, 2'd2);
    dmem_ready = 1'b1;
    step("redir_frz_release", C_RED, 2'd0);
`ifdef HAZARD_STATS_EN
    chk("flush_cnt_2", {4'd0, flush_count}, 8'd2);
    chk("freeze_cnt_5", {4'd0, freeze_cycles}, 8'd5);
`endif

    // Reset in the middle of a freeze
    idle();
    mem_opcode = OP_LOAD; dmem_ready = 1'b0;
    step("pre_reset_wait", C_WT, 2'd2);
    reset = 1'b1;
    step("reset_mid_frz", C_RUN, 2'd0);
`ifdef HAZARD_STATS_EN
    chk("rst_freeze_cnt", {4'd0, freeze_cycles}, 8'd0);
    chk("rst_flush_cnt", {4'd0, flush_count}, 8'd0);
`endif
    reset = 1'b0;
    idle();
    step("post_reset", C_RUN, 2'd0);

    // Twenty back-to-back load-use cycles saturate a 4-bit counter at 15
    ex_opcode = OP_LOAD; ex_rd = 5'd9; id_opcode = OP_RTYPE; id_rs1 = 5'd9;
    for (int i = 0; i < 20; i++) step("lu_sat", C_LU, 2'd1);
`ifdef HAZARD_STATS_EN
    chk("stall_sat_15", {4'd0, stall_cycles}, 8'd15);
`endif
    idle();
    step("final_idle", C_RUN, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/hazard_detection.md
# hazard_detection

Pipeline-control block that generates stall, freeze and flush controls for the five-stage RV32I pipeline. It is the stall-side counterpart to operand forwarding: forwarding consumes results already in EX/MEM and MEM/WB, while this block holds back the producers and consumers whose data cannot be forwarded in time. It covers three cases:
- load-use hazards;
- taken branches and jumps resolved in EX;
- data-memory wait states.

It sits in the top-level core next to the pipeline registers and drives their write-enable and flush inputs.

## Interface
Parameters:
- CNT_W, 32, width of the statistics counters (used only with HAZARD_STATS_EN)

Ports (clock and reset first; one clock, reset is synchronous and active-high):
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- id_rs1  input  5  rs1 field of the instruction in ID
- id_rs2  input  5  rs2 field of the instruction in ID
- id_opcode  input  7  opcode in ID
- ex_rd  input  5  rd of the instruction in EX
- ex_opcode  input  7  opcode in EX
- ex_redirect  input  1  EX resolved a taken branch, JAL or JALR
- mem_opcode  input  7  opcode in MEM
- dmem_ready  input  1  data memory completes the current access this cycle
- pc_write  output  1  PC register load enable
- if_id_write  output  1  IF/ID load enable
- if_id_flush  output  1  IF/ID loads a NOP
- id_ex_write  output  1  ID/EX load enable
- id_ex_flush  output  1  ID/EX loads a bubble (all write/mem controls 0, rd = 0)
- ex_mem_write  output  1  EX/MEM load enable
- mem_wb_flush  output  1  MEM/WB loads a bubble
- hz_state  output  2  current FSM state (debug)
- stall_cycles, flush_count, freeze_cycles  output  CNT_W each  statistics (present only with HAZARD_STATS_EN)

## Operation
Operand usage in ID:
- rs1 is used unless id_opcode is LUI, AUIPC or JAL.
- rs2 is used only for R-type, STORE and BRANCH.
- Register x0 never causes a hazard.

Hazard conditions:
- Load-use: ex_opcode == LOAD, ex_rd != 0, and ex_rd matches a used rs in ID.
- Memory wait: mem_opcode is LOAD or STORE and dmem_ready == 0.

FSM states:
- RUN = 0
- LU_STALL = 1 (one-cycle bubble being inserted)
- FREEZE = 2 (memory wait)

Priority each cycle, highest first: memory wait, redirect, load-use.

Memory wait:
- All write enables are 0 (pc_write, if_id_write, id_ex_write, ex_mem_write).
- mem_wb_flush = 1. No other flushes are asserted.
- Next state is FREEZE. The state remains FREEZE while the wait persists.

Redirect (no memory wait):
- if_id_flush = 1 and id_ex_flush = 1.
- All write enables are 1; the PC loads the target.
- Any concurrent load-use condition is ignored because the ID instruction is wrong-path.
- Next state is RUN.

Load-use (no memory wait, no redirect):
- pc_write = 0 and if_id_write = 0.
- id_ex_flush = 1.
- id_ex_write = 1 and ex_mem_write = 1.
- Next state is LU_STALL.

Otherwise:
- All write enables are 1 and all flushes are 0.
- Next state is RUN.

Further rules:
- LU_STALL always returns to RUN or FREEZE in the next cycle. Once the bubble has entered EX, ex_rd = 0 and cannot re-trigger the stall.
- A redirect arriving during FREEZE is held in EX by the freeze. The flush is applied in the first cycle with dmem_ready = 1.

## Timing
- All control outputs are combinational from the current inputs. Only the state and the counters are registered.
- Reset values:
  - state = RUN, so hz_state = 0;
  - counters = 0;
  - with reset held, outputs are the RUN/no-hazard values: all write enables 1, all flushes 0.
- A load-use stall costs exactly 1 cycle. A redirect costs 2 cycles: 2 instructions are squashed.
- A freeze lasts N cycles for N consecutive cycles of dmem_ready == 0.
- Reset asserted mid-FREEZE or mid-LU_STALL returns the state to RUN on the next edge and clears the counters.

## Configuration
Macro HAZARD_STATS_EN.

When defined, three counters increment by 1 per cycle:
- stall_cycles in load-use cycles;
- flush_count on redirect cycles;
- freeze_cycles in memory-wait cycles.

The counters saturate at all-ones, never wrap, and are cleared only by reset.

When not defined, the counter ports and logic are absent and the control behaviour is identical.

## Structure
Package hazard_pkg holds:
- opcode constants: OP_LOAD 0000011, OP_STORE 0100011, OP_BRANCH 1100011, OP_JAL 1101111, OP_JALR 1100111, OP_LUI 0110111, OP_AUIPC 0010111, OP_RTYPE 0110011;
- the 2-bit state enum.

One sub-module, hazard_stats, holds the three saturating counters. It is instantiated only under HAZARD_STATS_EN.

## Test plan
- **Load-use:** ex_opcode = LOAD, ex_rd = 5; id_opcode = R-type, id_rs2 = 5 → pc_write = 0, if_id_write = 0, id_ex_flush = 1, hz_state = 1 next cycle. In the following cycle with ex_rd = 0, all controls return to the RUN values.
- **No false stall:** ex_opcode = LOAD, ex_rd = 0, or id_opcode = LUI with id_rs1 = ex_rd = 7 → no stall, hz_state stays 0.
- **Redirect beats load-use:** ex_redirect = 1 in the same cycle as a load-use match → if_id_flush = 1, id_ex_flush = 1, pc_write = 1.
- **Memory wait:** mem_opcode = LOAD with dmem_ready low for 3 cycles → all write enables 0 and mem_wb_flush = 1 for 3 cycles, hz_state = 2. The pipeline resumes on the ready cycle. freeze_cycles = 3 with HAZARD_STATS_EN.
- **Redirect during freeze:** ex_redirect = 1 throughout a 2-cycle freeze → no flushes during the freeze; if_id_flush and id_ex_flush are asserted on the cycle dmem_ready = 1.
- **Reset mid-freeze:** reset asserted mid-freeze → state RUN next cycle, counters 0. Counter saturation check with CNT_W = 4: 20 stall cycles leave stall_cycles = 15.
